// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants, error-log cause codes and default memory-map values
// for the system bus matrix.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_DECODE  = 2'b01,
    ERR_SLAVE   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_cause_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } dslv_state_e;

  localparam int unsigned DEF_N_SLV     = 4;
  localparam logic [31:0] DEF_BASE_WORD = 32'h0000_0000;
  localparam logic [31:0] DEF_MASK_WORD = 32'hFFFF_FFFF;

  // NONSEQ and SEQ both carry bit 1; IDLE and BUSY never start a data phase.
  function automatic logic is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_sys_matrix_if.sv
// Bus bundle between the E902 BIU master port, the matrix and the N peripheral slaves.
// The master modport is the matrix view: it drives the slave-side bus and the master response.
interface ahb_sys_matrix_if #(
  parameter int unsigned N_SLV  = 4,
  parameter int unsigned DATA_W = 32
);
  logic [31:0]             m_haddr;
  logic [1:0]              m_htrans;
  logic                    m_hwrite;
  logic [2:0]              m_hsize;
  logic [2:0]              m_hburst;
  logic [3:0]              m_hprot;
  logic [DATA_W-1:0]       m_hwdata;
  logic [DATA_W-1:0]       m_hrdata;
  logic                    m_hready;
  logic [1:0]              m_hresp;

  logic [N_SLV-1:0]        s_hsel;
  logic [31:0]             s_haddr;
  logic [1:0]              s_htrans;
  logic                    s_hwrite;
  logic [2:0]              s_hsize;
  logic [2:0]              s_hburst;
  logic [3:0]              s_hprot;
  logic [DATA_W-1:0]       s_hwdata;
  logic                    s_hready;
  logic [N_SLV*DATA_W-1:0] s_hrdata;
  logic [N_SLV-1:0]        s_hreadyout;
  logic [N_SLV*2-1:0]      s_hresp;

  modport master (
    input  m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hprot, m_hwdata,
    output m_hrdata, m_hready, m_hresp,
    output s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot, s_hwdata, s_hready,
    input  s_hrdata, s_hreadyout, s_hresp
  );

  modport slave (
    output m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hprot, m_hwdata,
    input  m_hrdata, m_hready, m_hresp,
    input  s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot, s_hwdata, s_hready,
    output s_hrdata, s_hreadyout, s_hresp
  );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped accesses: answers each accepted transfer with the
// two-cycle AHB ERROR response. err_entry is high for the first ERROR cycle.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  output logic       hready,
  output logic [1:0] hresp,
  output logic       err_entry
);

  dslv_state_e state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DS_IDLE;
      hready    <= 1'b1;
      hresp     <= HRESP_OKAY;
      err_entry <= 1'b0;
    end else begin
      case (state)
        DS_ERR1: begin
          state     <= DS_ERR2;
          hready    <= 1'b1;
          hresp     <= HRESP_ERROR;
          err_entry <= 1'b0;
        end
        DS_ERR2, DS_IDLE: begin
          if (accept) begin
            state     <= DS_ERR1;
            hready    <= 1'b0;
            hresp     <= HRESP_ERROR;
            err_entry <= 1'b1;
          end else begin
            state     <= DS_IDLE;
            hready    <= 1'b1;
            hresp     <= HRESP_OKAY;
            err_entry <= 1'b0;
          end
        end
        default: begin
          state     <= DS_IDLE;
          hready    <= 1'b1;
          hresp     <= HRESP_OKAY;
          err_entry <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_sys_matrix.sv
// Single-master AHB-Lite system bus matrix: base/mask address decode, data-phase
// response steering, default ERROR slave, stall timeout and error capture log.
module ahb_sys_matrix
  import ahb_pkg::*;
#(
  parameter int unsigned           N_SLV    = DEF_N_SLV,
  parameter int unsigned           DATA_W   = 32,
  parameter logic [N_SLV*32-1:0]   SLV_BASE = {N_SLV{DEF_BASE_WORD}},
  parameter logic [N_SLV*32-1:0]   SLV_MASK = {N_SLV{DEF_MASK_WORD}},
  parameter int unsigned           TIMEOUT  = 256
) (
  input  logic                     sys_clk,
  input  logic                     sys_reset,
  ahb_sys_matrix_if.master         bus,
  input  logic                     err_clr,
  output logic                     err_vld,
  output logic                     err_ovf,
  output logic [1:0]               err_cause,
  output logic [31:0]              err_addr
);

  localparam int unsigned IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [IDX_W-1:0] hit_idx;
  logic             any_hit;
  logic             req;
  logic             dp_active;
  logic [IDX_W-1:0] dp_idx;
  logic [31:0]      dp_addr;
  logic             def_hready;
  logic [1:0]       def_hresp;
  logic             def_entry;
  logic [CNT_W-1:0] to_cnt;
  logic             to_event;
  logic             slv_err_seen;
  logic             slv_err_event;
  logic             ev;
  err_cause_e       ev_cause;

  assign req = is_active(bus.m_htrans);

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit_idx = '0;
    any_hit = 1'b0;
    for (int unsigned i = N_SLV; i > 0; i--) begin
      if ((bus.m_haddr & SLV_MASK[32*(i-1) +: 32]) ==
          (SLV_BASE[32*(i-1) +: 32] & SLV_MASK[32*(i-1) +: 32])) begin
        hit_idx = IDX_W'(i - 1);
        any_hit = 1'b1;
      end
    end
  end

  always_comb begin
    bus.s_hsel = '0;
    if (req && any_hit && !sys_reset) bus.s_hsel[hit_idx] = 1'b1;
  end

  assign bus.s_haddr  = bus.m_haddr;
  assign bus.s_htrans = bus.m_htrans;
  assign bus.s_hwrite = bus.m_hwrite;
  assign bus.s_hsize  = bus.m_hsize;
  assign bus.s_hburst = bus.m_hburst;
  assign bus.s_hprot  = bus.m_hprot;
  assign bus.s_hwdata = bus.m_hwdata;
  assign bus.s_hready = bus.m_hready;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      dp_active <= 1'b0;
      dp_idx    <= '0;
      dp_addr   <= '0;
    end else if (bus.m_hready) begin
      dp_active <= req && any_hit;
      dp_idx    <= hit_idx;
      dp_addr   <= bus.m_haddr;
    end
  end

  // Outside a real-slave data phase the default slave's registered response applies;
  // it idles at ready/OKAY, so this also covers the plain idle case.
  always_comb begin
    bus.m_hready = def_hready;
    bus.m_hresp  = def_hresp;
    bus.m_hrdata = '0;
    if (dp_active) begin
      bus.m_hready = bus.s_hreadyout[dp_idx];
      bus.m_hresp  = bus.s_hresp[2*dp_idx +: 2];
      bus.m_hrdata = bus.s_hrdata[DATA_W*dp_idx +: DATA_W];
    end
  end

  ahb_default_slave u_default_slave (
    .clk       (sys_clk),
    .rst       (sys_reset),
    .accept    (bus.m_hready && req && !any_hit),
    .hready    (def_hready),
    .hresp     (def_hresp),
    .err_entry (def_entry)
  );

  assign to_event = (TIMEOUT != 0) && dp_active && !bus.m_hready &&
                    (to_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      to_cnt <= '0;
    end else if (bus.m_hready) begin
      to_cnt <= '0;
    end else if ((TIMEOUT != 0) && dp_active && (to_cnt != CNT_W'(TIMEOUT))) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign slv_err_event = dp_active && (bus.m_hresp == HRESP_ERROR) && !slv_err_seen;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset)         slv_err_seen <= 1'b0;
    else if (bus.m_hready) slv_err_seen <= 1'b0;
    else if (slv_err_event) slv_err_seen <= 1'b1;
  end

  always_comb begin
    ev       = 1'b1;
    ev_cause = ERR_DECODE;
    if (def_entry)          ev_cause = ERR_DECODE;
    else if (slv_err_event) ev_cause = ERR_SLAVE;
    else if (to_event)      ev_cause = ERR_TIMEOUT;
    else begin
      ev       = 1'b0;
      ev_cause = ERR_NONE;
    end
  end

  // A new event alongside err_clr is captured as a fresh first error.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      err_vld   <= 1'b0;
      err_ovf   <= 1'b0;
      err_cause <= '0;
      err_addr  <= '0;
    end else if (ev) begin
      if (!err_vld || err_clr) begin
        err_vld   <= 1'b1;
        err_ovf   <= 1'b0;
        err_cause <= ev_cause;
        err_addr  <= dp_addr;
      end else begin
        err_ovf   <= 1'b1;
      end
    end else if (err_clr) begin
      err_vld <= 1'b0;
      err_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_sys_matrix.sv
// Self-checking bench for ahb_sys_matrix: directed cases from the memory-map
// scenarios plus randomized single transfers checked against a transfer-level model.
`timescale 1ns/1ps
module tb_ahb_sys_matrix;
  import ahb_pkg::*;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 256;
  localparam logic [NS*32-1:0] BASES = {32'h0000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hFF00_0000, 32'hF000_0000, 32'hFFF0_0000, 32'hF000_0000};
  localparam logic [31:0] WIN_BASE [NS] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [31:0] WIN_MASK [NS] = '{32'hF000_0000, 32'hFFF0_0000, 32'hF000_0000, 32'hFF00_0000};

  logic        sys_clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        err_clr = 1'b0;
  logic        err_vld, err_ovf;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;

  int ntests, nfail;

  ahb_sys_matrix_if #(.N_SLV(NS), .DATA_W(32)) bus();

  ahb_sys_matrix #(.N_SLV(NS), .DATA_W(32), .SLV_BASE(BASES), .SLV_MASK(MASKS), .TIMEOUT(TO)) dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .bus       (bus.master),
    .err_clr   (err_clr),
    .err_vld   (err_vld),
    .err_ovf   (err_ovf),
    .err_cause (err_cause),
    .err_addr  (err_addr)
  );

  always #5 sys_clk = ~sys_clk;

  // Peripheral responders: configurable wait states, optional two-cycle ERROR.
  int          cfg_wait [NS] = '{default: 0};
  bit          cfg_err  [NS] = '{default: 1'b0};
  bit          dact [NS];
  int          dcnt [NS];
  int          est  [NS];
  logic [31:0] dtag [NS];

  always @(posedge sys_clk or posedge sys_reset) begin
    for (int i = 0; i < NS; i++) begin
      if (sys_reset) begin
        dact[i] <= 1'b0; dcnt[i] <= 0; est[i] <= 0; dtag[i] <= '0;
      end else begin
        if (dact[i]) begin
          if (dcnt[i] > 0)       dcnt[i] <= dcnt[i] - 1;
          else if (est[i] == 1)  est[i] <= 2;
          else                   dact[i] <= 1'b0;
        end
        if (bus.s_hready && bus.s_hsel[i] && bus.s_htrans[1]) begin
          dact[i] <= 1'b1; dcnt[i] <= cfg_wait[i]; est[i] <= cfg_err[i] ? 1 : 0; dtag[i] <= bus.s_haddr;
        end
      end
    end
  end

  always_comb begin
    bus.s_hreadyout = '1;
    bus.s_hresp     = '0;
    bus.s_hrdata    = '0;
    for (int i = 0; i < NS; i++) begin
      if (dact[i]) begin
        if (dcnt[i] > 0) bus.s_hreadyout[i] = 1'b0;
        else if (est[i] == 1) begin bus.s_hreadyout[i] = 1'b0; bus.s_hresp[2*i +: 2] = HRESP_ERROR; end
        else if (est[i] == 2) bus.s_hresp[2*i +: 2] = HRESP_ERROR;
        else bus.s_hrdata[32*i +: 32] = {4'(i), dtag[i][27:0]};
      end
    end
  end

  // Error-log reference state.
  bit          mdl_vld, mdl_ovf;
  logic [1:0]  mdl_cause;
  logic [31:0] mdl_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_apply(input bit ev, input logic [1:0] c, input logic [31:0] a, input bit clr);
    if (ev && (!mdl_vld || clr)) begin mdl_vld = 1; mdl_ovf = 0; mdl_cause = c; mdl_addr = a; end
    else if (ev) mdl_ovf = 1;
    else if (clr) begin mdl_vld = 0; mdl_ovf = 0; end
  endtask

  function automatic int mdl_target(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & WIN_MASK[i]) == (WIN_BASE[i] & WIN_MASK[i])) return i;
    return -1;
  endfunction

  task automatic chk_log(input string tag);
    chk({tag, "_vld"},   err_vld,   mdl_vld);
    chk({tag, "_ovf"},   err_ovf,   mdl_ovf);
    chk({tag, "_cause"}, err_cause, mdl_cause);
    chk({tag, "_addr"},  err_addr,  mdl_addr);
  endtask

  task automatic clear_log();
    err_clr = 1'b1;
    mdl_apply(1'b0, 2'b00, 32'h0, 1'b1);
    @(negedge sys_clk);
    err_clr = 1'b0;
    chk("clr_vld", err_vld, mdl_vld);
  endtask

  // One isolated transfer; entered and left on a falling edge with the bus idle.
  task automatic xfer(input logic [31:0] addr, input logic [1:0] trans, input int clr_cyc);
    int tgt, ncyc, exp_cyc, wt, dec_cyc, se_cyc, to_cyc;
    bit act, serr, done, ev;
    logic [1:0] r1, rl, c, exp_r1, exp_rl;
    logic [31:0] rd, exp_rd;
    tgt = mdl_target(addr);
    act = trans[1];
    wt = (act && tgt >= 0) ? cfg_wait[tgt] : 0;
    serr = (act && tgt >= 0) ? cfg_err[tgt] : 1'b0;
    dec_cyc = (act && tgt < 0) ? 1 : 0;
    se_cyc = serr ? wt + 1 : 0;
    to_cyc = (act && tgt >= 0 && (wt + int'(serr)) >= TO) ? TO : 0;
    if (act && tgt >= 0) begin
      exp_cyc = wt + int'(serr) + 1;
      exp_r1 = (wt == 0 && serr) ? HRESP_ERROR : HRESP_OKAY;
      exp_rl = serr ? HRESP_ERROR : HRESP_OKAY;
      exp_rd = serr ? 32'h0 : {4'(tgt), addr[27:0]};
    end else if (act) begin
      exp_cyc = 2; exp_r1 = HRESP_ERROR; exp_rl = HRESP_ERROR; exp_rd = 32'h0;
    end else begin
      exp_cyc = 1; exp_r1 = HRESP_OKAY; exp_rl = HRESP_OKAY; exp_rd = 32'h0;
    end

    bus.m_haddr = addr; bus.m_htrans = trans;
    bus.m_hwrite = 1'($urandom_range(0, 1)); bus.m_hwdata = $urandom;
    #1;
    chk("hsel", bus.s_hsel, (act && tgt >= 0) ? (32'h1 << tgt) : 32'h0);
    @(negedge sys_clk);
    bus.m_htrans = HTRANS_IDLE;

    ncyc = 0; done = 0; r1 = 2'bxx; rl = 2'bxx; rd = 'x;
    while (!done && ncyc < 1000) begin
      ncyc++;
      if (ncyc == 1) r1 = bus.m_hresp;
      chk("vld_cycle", err_vld, mdl_vld);
      if (bus.m_hready) begin done = 1; rl = bus.m_hresp; rd = bus.m_hrdata; end
      if (clr_cyc == ncyc) err_clr = 1'b1;
      ev = 1'b1;
      if (ncyc == dec_cyc)     c = ERR_DECODE;
      else if (ncyc == se_cyc) c = ERR_SLAVE;
      else if (ncyc == to_cyc) c = ERR_TIMEOUT;
      else begin ev = 1'b0; c = 2'b00; end
      mdl_apply(ev, c, addr, clr_cyc == ncyc);
      @(negedge sys_clk);
      err_clr = 1'b0;
    end
    chk("completed", 32'(done), 32'h1);
    chk("cycles", ncyc, exp_cyc);
    chk("resp_first", r1, exp_r1);
    chk("resp_last", rl, exp_rl);
    chk("rdata", rd, exp_rd);
    chk_log("log");
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  tr;
    ntests = 0; nfail = 0;
    mdl_vld = 0; mdl_ovf = 0; mdl_cause = 2'b00; mdl_addr = 32'h0;
    bus.m_haddr = 32'h0; bus.m_htrans = HTRANS_IDLE; bus.m_hwrite = 1'b0;
    bus.m_hsize = 3'b010; bus.m_hburst = 3'b000; bus.m_hprot = 4'b0011; bus.m_hwdata = 32'h0;

    repeat (3) @(negedge sys_clk);
    chk("rst_hready", bus.m_hready, 1);
    chk("rst_hresp", bus.m_hresp, HRESP_OKAY);
    chk("rst_hrdata", bus.m_hrdata, 0);
    chk("rst_hsel", bus.s_hsel, 0);
    chk_log("rst");
    sys_reset = 1'b0;
    @(negedge sys_clk);

    xfer(32'h2000_0010, HTRANS_NONSEQ, 0);
    xfer(32'h9000_0000, HTRANS_NONSEQ, 0);
    clear_log();
    xfer(32'h9000_0004, HTRANS_IDLE, 0);
    xfer(32'h9000_0008, HTRANS_BUSY, 0);

    cfg_wait[0] = 300;
    xfer(32'h0500_0040, HTRANS_NONSEQ, 0);
    cfg_wait[0] = 0;

    cfg_err[2] = 1'b1;
    xfer(32'h4000_0100, HTRANS_SEQ, 0);
    cfg_err[2] = 1'b0;
    xfer(32'h9123_4560, HTRANS_NONSEQ, 1);

    xfer(32'h0000_1234, HTRANS_NONSEQ, 0);
    xfer(32'h00FF_0000, HTRANS_SEQ, 0);

    for (int n = 0; n < 60; n++) begin
      for (int s = 0; s < NS; s++) begin
        cfg_wait[s] = $urandom_range(0, 4);
        cfg_err[s]  = ($urandom_range(0, 3) == 0);
      end
      case ($urandom_range(0, 5))
        0: a = {4'h0, 4'($urandom_range(1, 15)), 24'($urandom)};
        1: a = {12'h200, 20'($urandom)};
        2: a = {4'h4, 28'($urandom)};
        3: a = {8'h00, 24'($urandom)};
        4: a = {4'h9, 28'($urandom)};
        default: a = {12'h201, 20'($urandom)};
      endcase
      tr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) clear_log();
      xfer(a, tr, ($urandom_range(0, 5) == 0) ? 1 : 0);
    end
    for (int s = 0; s < NS; s++) begin cfg_wait[s] = 0; cfg_err[s] = 1'b0; end

    // Reset in the middle of a stalled data phase.
    cfg_wait[2] = 20;
    bus.m_haddr = 32'h4000_0200; bus.m_htrans = HTRANS_NONSEQ;
    @(negedge sys_clk);
    bus.m_htrans = HTRANS_IDLE;
    repeat (3) @(negedge sys_clk);
    chk("rst_mid_wait", bus.m_hready, 0);
    bus.m_haddr = 32'h2000_0000; bus.m_htrans = HTRANS_NONSEQ;
    #2 sys_reset = 1'b1;
    @(posedge sys_clk); #1;
    chk("rst2_hready", bus.m_hready, 1);
    chk("rst2_hresp", bus.m_hresp, HRESP_OKAY);
    chk("rst2_hrdata", bus.m_hrdata, 0);
    chk("rst2_hsel", bus.s_hsel, 0);
    mdl_vld = 0; mdl_ovf = 0; mdl_cause = 2'b00; mdl_addr = 32'h0;
    chk_log("rst2");
    @(negedge sys_clk);
    bus.m_htrans = HTRANS_IDLE;
    sys_reset = 1'b0;
    cfg_wait[2] = 0;
    @(negedge sys_clk);
    xfer(32'h2000_0ABC, HTRANS_NONSEQ, 0);
    xfer(32'h4000_0200, HTRANS_NONSEQ, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
